// File: rtl/key_conditioner.sv
// Four-key button conditioner: synchronise, debounce and edge-detect active-low buttons into one-cycle press pulses.
// Optional auto-repeat while a key stays held is enabled by defining KEY_REPEAT_EN.
module key_conditioner #(
    parameter int DEBOUNCE_CYC  = 500_000,
    parameter int REPEAT_DELAY  = 12_500_000,
    parameter int REPEAT_PERIOD = 2_500_000
) (
    input  logic       vga_clk,
    input  logic       sys_rst_n,
    input  logic [3:0] key_n,
    output logic       key_up,
    output logic       key_down,
    output logic       key_left,
    output logic       key_right,
    output logic       key_press,
    output logic [3:0] key_held
);

    localparam int NKEY  = 4;
    localparam int CNT_W = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    generate
        if (DEBOUNCE_CYC < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2 ||
            REPEAT_PERIOD > REPEAT_DELAY) begin : g_param_err
            $error("key_conditioner: illegal parameter set");
        end
    endgenerate

    logic [NKEY-1:0]  r_sync1;
    logic [NKEY-1:0]  r_sync2;
    logic [NKEY-1:0]  r_stable;
    logic [NKEY-1:0]  r_held;
    logic [NKEY-1:0]  r_pulse;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt [NKEY];

    logic [NKEY-1:0]  w_stable_nxt;
    logic [CNT_W-1:0] w_cnt_nxt [NKEY];
    logic [NKEY-1:0]  w_rise;
    logic [NKEY-1:0]  w_pulse_nxt;

    // Two-flop synchroniser; inverts so downstream logic sees active-high pressed.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync1 <= 4'h0;
            r_sync2 <= 4'h0;
        end else begin
            r_sync1 <= ~key_n;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce next-state: any cycle of agreement restarts the qualifying count.
    always_comb begin
        w_stable_nxt = r_stable;
        for (int k = 0; k < NKEY; k++) begin
            w_cnt_nxt[k] = CNT_ZERO;
            if (r_sync2[k] == r_stable[k]) begin
                w_cnt_nxt[k] = CNT_ZERO;
            end else if (r_cnt[k] == CNT_LAST) begin
                w_stable_nxt[k] = r_sync2[k];
                w_cnt_nxt[k]    = CNT_ZERO;
            end else begin
                w_cnt_nxt[k] = r_cnt[k] + CNT_ONE;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_stable <= 4'h0;
            for (int k = 0; k < NKEY; k++) begin
                r_cnt[k] <= CNT_ZERO;
            end
        end else begin
            r_stable <= w_stable_nxt;
            for (int k = 0; k < NKEY; k++) begin
                r_cnt[k] <= w_cnt_nxt[k];
            end
        end
    end

    // r_held lags r_stable by one cycle, so it doubles as the edge-detect history.
    assign w_rise = r_stable & ~r_held;

`ifdef KEY_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_ZERO   = {RPT_W{1'b0}};
    localparam logic [RPT_W-1:0] RPT_ONE    = RPT_W'(1'b1);
    localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [RPT_W-1:0] r_rpt [NKEY];
    logic [RPT_W-1:0] w_rpt_nxt [NKEY];
    logic [NKEY-1:0]  w_rpt_fire;

    // Repeat timer: reloading to DELAY-PERIOD makes later pulses PERIOD apart.
    always_comb begin
        w_rpt_fire = 4'h0;
        for (int k = 0; k < NKEY; k++) begin
            w_rpt_nxt[k] = RPT_ZERO;
            if (!r_stable[k] || w_rise[k]) begin
                w_rpt_nxt[k] = RPT_ZERO;
            end else if (r_rpt[k] == RPT_LAST) begin
                w_rpt_fire[k] = w_stable_nxt[k];
                w_rpt_nxt[k]  = RPT_RELOAD;
            end else begin
                w_rpt_nxt[k] = r_rpt[k] + RPT_ONE;
            end
        end
    end

    // Repeat timer registers.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int k = 0; k < NKEY; k++) begin
                r_rpt[k] <= RPT_ZERO;
            end
        end else begin
            for (int k = 0; k < NKEY; k++) begin
                r_rpt[k] <= w_rpt_nxt[k];
            end
        end
    end

    assign w_pulse_nxt = w_rise | w_rpt_fire;
`else
    assign w_pulse_nxt = w_rise;
`endif

    // Output registers; key_press is registered alongside the pulses it summarises.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_held  <= 4'h0;
            r_pulse <= 4'h0;
            r_press <= 1'b0;
        end else begin
            r_held  <= r_stable;
            r_pulse <= w_pulse_nxt;
            r_press <= |w_pulse_nxt;
        end
    end

    assign key_up    = r_pulse[0];
    assign key_down  = r_pulse[1];
    assign key_left  = r_pulse[2];
    assign key_right = r_pulse[3];
    assign key_press = r_press;
    assign key_held  = r_held;

endmodule
